gui_control: RTL

GUI_CONTROL -- requirements
Module: gui_control

---
 rtl/gui_control.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gui_control.sv
// Sidebar GUI controller: three auto-repeating buttons and pointer clicks drive the
// palette index and stroke width; clicks right of the sidebar are forwarded to the canvas.
module gui_control #(
  parameter int unsigned HOLD_CYCLES   = 37_125_000,
  parameter int unsigned REPEAT_CYCLES = 7_425_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_color,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        click_valid,
  input  logic [10:0] click_x,
  input  logic [9:0]  click_y,
  output logic [3:0]  cursor_color,
  output logic [2:0]  stroke_width,
  output logic        canvas_click_valid,
  output logic [10:0] canvas_x,
  output logic [9:0]  canvas_y,
  output logic        settings_changed
);

  // state     | meaning
  // IDLE      | button released; a rising edge emits one step
  // WAIT_HOLD | first step done, counting towards the hold threshold
  // REPEAT    | auto-repeat, one step every REPEAT_CYCLES
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } btn_state_t;

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned BTN_COLOR = 0;
  localparam int unsigned BTN_UP    = 1;
  localparam int unsigned BTN_DOWN  = 2;

  localparam logic [25:0] HOLD_LAST   = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] prev_q;
  logic [NUM_BTN-1:0] step;
  btn_state_t         state_q [NUM_BTN];
  btn_state_t         state_d [NUM_BTN];
  logic [25:0]        count_q [NUM_BTN];
  logic [25:0]        count_d [NUM_BTN];

  assign btn = {btn_down, btn_up, btn_color};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        count_q[i] <= '0;
      end
    end else begin
      prev_q <= btn;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  always_comb begin
    step = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      if (!btn[i]) begin
        state_d[i] = IDLE;
        count_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (!prev_q[i]) begin
              step[i]    = 1'b1;
              state_d[i] = WAIT_HOLD;
              count_d[i] = '0;
            end
          end
          WAIT_HOLD: begin
            if (count_q[i] == HOLD_LAST) begin
              step[i]    = 1'b1;
              state_d[i] = REPEAT;
              count_d[i] = '0;
            end else begin
              count_d[i] = count_q[i] + 26'd1;
            end
          end
          REPEAT: begin
            if (count_q[i] == REPEAT_LAST) begin
              step[i]    = 1'b1;
              count_d[i] = '0;
            end else begin
              count_d[i] = count_q[i] + 26'd1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            count_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Click classification: everything at x <= 100 belongs to the sidebar
  logic       sidebar_click;
  logic       canvas_click;
  logic       color_click;
  logic       width_click;
  logic [2:0] click_width;

  always_comb begin
    sidebar_click = click_valid && (click_x <= 11'd100);
    canvas_click  = click_valid && (click_x > 11'd100);
    color_click   = sidebar_click
                    && (click_x >= 11'd20) && (click_x <= 11'd80)
                    && (click_y >= 10'd20) && (click_y <= 10'd80);
    width_click   = sidebar_click
                    && (click_x >= 11'd40) && (click_x <= 11'd60)
                    && (click_y >= 10'd610) && (click_y <= 10'd700);
    if (click_y >= 10'd680)      click_width = 3'd0;
    else if (click_y >= 10'd670) click_width = 3'd1;
    else if (click_y >= 10'd660) click_width = 3'd2;
    else if (click_y >= 10'd650) click_width = 3'd3;
    else if (click_y >= 10'd640) click_width = 3'd4;
    else if (click_y >= 10'd630) click_width = 3'd5;
    else if (click_y >= 10'd620) click_width = 3'd6;
    else                         click_width = 3'd7;
  end

  logic [3:0] color_d;
  logic [2:0] width_d;

  always_comb begin
    color_d = cursor_color;
    if (step[BTN_COLOR] || color_click) begin
      color_d = cursor_color + 4'd1;
    end
    width_d = stroke_width;
    if (width_click) begin
      width_d = click_width;
    end else if (step[BTN_UP] && !step[BTN_DOWN]) begin
      if (stroke_width != 3'd7) width_d = stroke_width + 3'd1;
    end else if (step[BTN_DOWN] && !step[BTN_UP]) begin
      if (stroke_width != 3'd0) width_d = stroke_width - 3'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cursor_color       <= 4'd1;
      stroke_width       <= 3'd1;
      settings_changed   <= 1'b0;
      canvas_click_valid <= 1'b0;
      canvas_x           <= '0;
      canvas_y           <= '0;
    end else begin
      cursor_color       <= color_d;
      stroke_width       <= width_d;
      settings_changed   <= (color_d != cursor_color) || (width_d != stroke_width);
      canvas_click_valid <= canvas_click;
      if (canvas_click) begin
        canvas_x <= click_x;
        canvas_y <= click_y;
      end
    end
  end

endmodule
